// File: rtl/proc8_bus_pkg.sv
// Shared definitions for the 8-bit processor memory bus: arbiter FSM
// states, requester identifiers, bus width and wait-counter width.
package proc8_bus_pkg;

  localparam int BUS_W = 8;
  localparam int CNT_W = 4;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_AUX = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

endpackage : proc8_bus_pkg

// File: rtl/bus_arb_pick.sv
// Combinational winner select for the two-master memory bus.
// Build option ARB_FIXED_PRIO_EN: when defined, requester 0 (processor)
// always wins a tie; otherwise a tie goes to the requester not served last.
import proc8_bus_pkg::*;

module bus_arb_pick (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic valid_o,
  output logic id_o
);

  // Pick a winner among the active requesters.
  always_comb begin
    valid_o = 1'b0;
    id_o    = REQ_CPU;
    case ({req1_i, req0_i})
      2'b01: begin
        valid_o = 1'b1;
        id_o    = REQ_CPU;
      end
      2'b10: begin
        valid_o = 1'b1;
        id_o    = REQ_AUX;
      end
      2'b11: begin
        valid_o = 1'b1;
`ifdef ARB_FIXED_PRIO_EN
        id_o    = REQ_CPU;
`else
        id_o    = ~last_i;
`endif
      end
      default: begin
        valid_o = 1'b0;
        id_o    = REQ_CPU;
      end
    endcase
  end

endmodule : bus_arb_pick

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter and transaction sequencer for the shared 8-bit memory
// bus. One transaction at a time: IDLE (arbitrate) -> ACCESS (strobe held
// WAIT_CYCLES cycles) -> DONE (one-cycle done pulse). Tie-break policy is
// chosen in bus_arb_pick via ARB_FIXED_PRIO_EN.
import proc8_bus_pkg::*;

module mem_bus_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [BUS_W-1:0] addr0,
  input  logic [BUS_W-1:0] addr1,
  input  logic [BUS_W-1:0] wdata0,
  input  logic [BUS_W-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [BUS_W-1:0] rdata,
  output logic [BUS_W-1:0] add,
  output logic             rd,
  output logic             wrt,
  output logic [BUS_W-1:0] mem_dout,
  input  logic [BUS_W-1:0] mem_din
);

  // Counter counts down to zero; zero marks the final strobe cycle.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  arb_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             last_q;
  logic             owner_q;
  logic             we_q;
  logic             gnt0_q;
  logic             gnt1_q;
  logic             done0_q;
  logic             done1_q;
  logic             rd_q;
  logic             wrt_q;
  logic [BUS_W-1:0] add_q;
  logic [BUS_W-1:0] mem_dout_q;
  logic [BUS_W-1:0] rdata_q;

  logic             pick_valid;
  logic             pick_id;
  logic             pick_we;

  bus_arb_pick u_pick (
    .req0_i  (req0),
    .req1_i  (req1),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .id_o    (pick_id)
  );

  assign pick_we = (pick_id == REQ_AUX) ? we1 : we0;

  // Next value of the wait counter (saturates at zero).
  always_comb begin
    if (cnt_q != {CNT_W{1'b0}}) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
  end

  // Transaction FSM with operand latches and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= {CNT_W{1'b0}};
      last_q     <= REQ_AUX;
      owner_q    <= REQ_CPU;
      we_q       <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      rd_q       <= 1'b0;
      wrt_q      <= 1'b0;
      add_q      <= {BUS_W{1'b0}};
      mem_dout_q <= {BUS_W{1'b0}};
      rdata_q    <= {BUS_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            owner_q    <= pick_id;
            we_q       <= pick_we;
            add_q      <= (pick_id == REQ_AUX) ? addr1 : addr0;
            mem_dout_q <= (pick_id == REQ_AUX) ? wdata1 : wdata0;
            gnt0_q     <= (pick_id == REQ_CPU);
            gnt1_q     <= (pick_id == REQ_AUX);
            rd_q       <= ~pick_we;
            wrt_q      <= pick_we;
            cnt_q      <= CNT_LOAD;
            state_q    <= ACCESS;
          end else begin
            state_q    <= IDLE;
          end
        end
        ACCESS: begin
          if (cnt_q == {CNT_W{1'b0}}) begin
            rd_q    <= 1'b0;
            wrt_q   <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= (owner_q == REQ_CPU);
            done1_q <= (owner_q == REQ_AUX);
            if (!we_q) begin
              rdata_q <= mem_din;
            end else begin
              rdata_q <= rdata_q;
            end
            state_q <= DONE;
          end else begin
            cnt_q   <= cnt_d;
            state_q <= ACCESS;
          end
        end
        DONE: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          last_q  <= owner_q;
          state_q <= IDLE;
        end
        default: begin
          rd_q    <= 1'b0;
          wrt_q   <= 1'b0;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign done0    = done0_q;
  assign done1    = done1_q;
  assign rdata    = rdata_q;
  assign add      = add_q;
  assign rd       = rd_q;
  assign wrt      = wrt_q;
  assign mem_dout = mem_dout_q;

endmodule : mem_bus_arbiter

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter. Three instances share the inputs,
// built with WAIT_CYCLES = 1, 3 and 4; each scenario checks one of them.
module tb_mem_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, we0, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1, mem_din;

  logic       g0 [3];
  logic       g1 [3];
  logic       d0 [3];
  logic       d1 [3];
  logic       rdv [3];
  logic       wrv [3];
  logic [7:0] addv [3];
  logic [7:0] doutv [3];
  logic [7:0] rdat [3];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WC = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    mem_bus_arbiter #(.WAIT_CYCLES(WC)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .req0     (req0),
      .req1     (req1),
      .we0      (we0),
      .we1      (we1),
      .addr0    (addr0),
      .addr1    (addr1),
      .wdata0   (wdata0),
      .wdata1   (wdata1),
      .gnt0     (g0[g]),
      .gnt1     (g1[g]),
      .done0    (d0[g]),
      .done1    (d1[g]),
      .rdata    (rdat[g]),
      .add      (addv[g]),
      .rd       (rdv[g]),
      .wrt      (wrv[g]),
      .mem_dout (doutv[g]),
      .mem_din  (mem_din)
    );
  end

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [6:0] e_g0, e_g1, e_d0;
  int         exp_id;
  int         cnt_w, cnt_d;

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00; mem_din = 8'h00;
    repeat (3) tick();

    // Reset values on every instance
    for (int i = 0; i < 3; i++) begin
      check_eq("rst_ctl", {10'd0, g0[i], g1[i], d0[i], d1[i], rdv[i], wrv[i]}, 16'h0000);
      check_eq("rst_add", {8'h00, addv[i]}, 16'h0000);
      check_eq("rst_dout", {8'h00, doutv[i]}, 16'h0000);
      check_eq("rst_rdata", {8'h00, rdat[i]}, 16'h0000);
    end
    rst = 1'b0;

    // Single read, WAIT_CYCLES=1 (instance 0)
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h20; mem_din = 8'h5A;
    tick();
    check_eq("rd1_gnt", {14'd0, g1[0], g0[0]}, 16'h0001);
    check_eq("rd1_strb", {14'd0, wrv[0], rdv[0]}, 16'h0001);
    check_eq("rd1_add", {8'h00, addv[0]}, 16'h0020);
    req0 = 1'b0;
    tick();
    check_eq("rd1_done", {13'd0, d0[0], g0[0], rdv[0]}, 16'h0004);
    check_eq("rd1_rdata", {8'h00, rdat[0]}, 16'h005A);
    tick();
    check_eq("rd1_done_end", {15'd0, d0[0]}, 16'h0000);
    repeat (4) tick();

    // Single write, WAIT_CYCLES=3 (instance 1); rdata holds 0x5A from the read
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h81; wdata1 = 8'hC3; mem_din = 8'hEE;
    tick();
    check_eq("wr3_gnt", {14'd0, g1[1], g0[1]}, 16'h0002);
    check_eq("wr3_strb0", {14'd0, wrv[1], rdv[1]}, 16'h0002);
    check_eq("wr3_add", {8'h00, addv[1]}, 16'h0081);
    check_eq("wr3_dout", {8'h00, doutv[1]}, 16'h00C3);
    req1 = 1'b0;
    for (int k = 1; k < 3; k++) begin
      tick();
      check_eq("wr3_strb", {14'd0, wrv[1], rdv[1]}, 16'h0002);
    end
    tick();
    check_eq("wr3_done", {13'd0, d1[1], g1[1], wrv[1]}, 16'h0004);
    check_eq("wr3_rdata_kept", {8'h00, rdat[1]}, 16'h005A);
    tick();
    check_eq("wr3_done_end", {15'd0, d1[1]}, 16'h0000);

    // Tie held for four transactions (instance 0)
    do_reset();
    we0 = 1'b0; we1 = 1'b0; addr0 = 8'h10; addr1 = 8'h11; mem_din = 8'h00;
    req0 = 1'b1; req1 = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
`ifdef ARB_FIXED_PRIO_EN
      exp_id = 0;
`else
      exp_id = n % 2;
`endif
      check_eq("tie_gnt", {14'd0, g1[0], g0[0]}, (exp_id == 1) ? 16'h0002 : 16'h0001);
      check_eq("tie_add", {8'h00, addv[0]}, (exp_id == 1) ? 16'h0011 : 16'h0010);
      tick();
      check_eq("tie_done", {14'd0, d1[0], d0[0]}, (exp_id == 1) ? 16'h0002 : 16'h0001);
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;

    // Overlap: req1 rises during requester 0 ACCESS (instance 2, W=4)
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h30; mem_din = 8'h77;
    e_g0 = 7'b0001111; e_g1 = 7'b1000000; e_d0 = 7'b0010000;
    tick();
    req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 8'h40;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) tick();
      check_eq("ovl_gnt", {13'd0, d0[2], g1[2], g0[2]}, {13'd0, e_d0[k], e_g1[k], e_g0[k]});
      check_eq("ovl_mutex", {15'd0, g0[2] & g1[2]}, 16'h0000);
    end
    check_eq("ovl_add1", {8'h00, addv[2]}, 16'h0040);
    check_eq("ovl_rdata0", {8'h00, rdat[2]}, 16'h0077);
    req1 = 1'b0; mem_din = 8'h88;
    repeat (4) tick();
    check_eq("ovl_done1", {14'd0, d1[2], g1[2]}, 16'h0002);
    check_eq("ovl_rdata1", {8'h00, rdat[2]}, 16'h0088);
    tick();

    // Reset during the second strobe cycle (instance 2)
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h55;
    tick();
    check_eq("rstm_rd1", {15'd0, rdv[2]}, 16'h0001);
    tick();
    check_eq("rstm_rd2", {15'd0, rdv[2]}, 16'h0001);
    rst = 1'b1; req0 = 1'b0;
    tick();
    check_eq("rstm_clear", {11'd0, g0[2], g1[2], d0[2], rdv[2], wrv[2]}, 16'h0000);
    rst = 1'b0;
    cnt_d = 0;
    repeat (6) begin
      tick();
      cnt_d += int'(d0[2]);
    end
    check_eq("rstm_no_done", cnt_d[15:0], 16'h0000);
    req0 = 1'b1; addr0 = 8'h66; mem_din = 8'h99;
    tick();
    check_eq("rstm_regnt", {14'd0, g0[2], rdv[2]}, 16'h0003);
    check_eq("rstm_add", {8'h00, addv[2]}, 16'h0066);
    req0 = 1'b0;
    repeat (4) tick();
    check_eq("rstm_done", {15'd0, d0[2]}, 16'h0001);
    check_eq("rstm_rdata", {8'h00, rdat[2]}, 16'h0099);

    // Request dropped in first ACCESS cycle (instance 2, write)
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h77; wdata0 = 8'h12;
    tick();
    check_eq("drop_wrt", {15'd0, wrv[2]}, 16'h0001);
    check_eq("drop_dout", {8'h00, doutv[2]}, 16'h0012);
    req0 = 1'b0;
    cnt_w = 1; cnt_d = 0;
    repeat (8) begin
      tick();
      cnt_w += int'(wrv[2]);
      cnt_d += int'(d0[2]);
    end
    check_eq("drop_wrt_len", cnt_w[15:0], 16'h0004);
    check_eq("drop_done_cnt", cnt_d[15:0], 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_mem_bus_arbiter
